instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer side of the instruction memory. It receives a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words. It drives the instruction memory write port and holds the processor in reset while a program is loading. A trailing checksum reports whether the load succeeded.

Parameters:
DEPTH, 128, number of 32-bit words in instruction memory (must be ≤255)
ADDR_W, 7, word-address width, equal to clog2(DEPTH)
SYNC, 8'hA5, frame start byte

Ports:
CLK  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
RxData  input  8  received byte
RxValid  input  1  RxData valid this cycle
RxReady  output  1  loader accepts a byte; transfer happens when RxValid & RxReady
WE  output  1  instruction memory write enable, one-cycle pulse
WA  output  ADDR_W  word address for the write
WD  output  32  word to write
CpuHold  output  1  holds the processor in reset while a load is in progress
Done  output  1  one-cycle pulse when a load completes with a good checksum
Error  output  1  sticky; set on a bad length or bad checksum, cleared by the next accepted SYNC byte

Behaviour:
- Reset is synchronous and active-high. While Reset is high or after it deasserts, all outputs are 0 (RxReady=0, WE=0, WA=0, WD=0, CpuHold=0, Done=0, Error=0); the state is IDLE, and the byte index, word index and checksum are cleared.
- Reset mid-load aborts the frame. A partially assembled word is discarded; words already written stay in memory.
- RxReady is registered and goes to 1 on the first cycle after Reset deasserts. It stays 1 in every state.
- A "byte" below means an accepted transfer (RxValid & RxReady).
- State IDLE:
  - a byte equal to SYNC -> state LEN; CpuHold=1, Error=0, checksum=0.
  - any other byte is dropped.
- State LEN: the byte is N, the word count.
  - N==0 or N>DEPTH -> back to IDLE; Error=1, CpuHold=0, no writes.
  - otherwise store N, checksum=N, word index=0, byte index=0 -> state DATA.
- State DATA:
  - the byte with index k (0..3) goes into WD bits [8k+7:8k], so the first byte is the LSB.
  - checksum += byte, modulo 256.
  - when k==3 is accepted at cycle t: at t+1, WE=1, WA=word index, and WD holds the complete word. WE is 0 on all other cycles.
  - the word index increments after each completed word.
  - after word N-1 completes -> state CSUM.
- State CSUM: compare the byte with the checksum.
  - match -> Done=1 for one cycle, Error=0.
  - mismatch -> Error=1.
  - either way CpuHold=0 on the following cycle, and the state returns to IDLE.
  - the last WE pulse always falls at or before the cycle in which the CSUM byte is accepted.
- Gaps of any length between bytes are allowed. There is no timeout.
- WA/WD hold their last values when WE=0.
- A SYNC byte arriving inside DATA or CSUM is treated as data or checksum, not as a restart.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum {IDLE, LEN, DATA, CSUM};
  - the SYNC default;
  - the function computing ADDR_W.
- One natural sub-module, word_assembler. It takes the byte, the accept strobe and a clear input. It outputs the 32-bit word, the byte index and a word_complete strobe. The FSM, counters, checksum and write-port registers stay in the top level.

Test Plan:
- Single-word load. Send A5 01 04 12 9F E5 9B -> one WE pulse with WA=0, WD=32'hE59F1204; then Done pulse, Error=0. CpuHold is high from the cycle after A5 until the cycle after 9B.
- Three-word load. Send the words E59F1204, E59F9204, E59F8204 with a correct checksum and random RxValid gaps -> WE at WA=0,1,2 with those values, in order; Done=1.
- Bad checksum. Same as the first case but the last byte is 9C -> the word is still written at WA=0; Error=1 sticky, no Done, CpuHold returns to 0.
- Bad length. Send A5 00 and, separately, A5 81 (129 > DEPTH) -> no WE, Error=1, state IDLE. Then send a valid frame -> Error clears on its A5 byte, and the frame loads.
- Noise and reset. Send 00 FF 12 before A5 -> the noise is ignored. Assert Reset after 2 data bytes -> all outputs are 0 and no WE. A fresh frame afterwards loads at WA=0.
- Full depth. Load N=128 words with value = index -> the last write is at WA=127, WD=32'h0000007F; Done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader top level and its word assembler.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    CSUM
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted bytes into a little-endian 32-bit word.
// The fourth byte is passed through so the word is complete on its strobe.
module word_assembler (
  input  logic        clk,
  input  logic [7:0]  rx_byte,
  input  logic        accept,
  input  logic        clear,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_complete
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] low_q, low_d;

  always_comb begin
    idx_d = idx_q;
    low_d = low_q;
    if (clear) begin
      idx_d = 2'd0;
      low_d = 24'd0;
    end else if (accept) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0:    low_d[7:0]   = rx_byte;
        2'd1:    low_d[15:8]  = rx_byte;
        2'd2:    low_d[23:16] = rx_byte;
        default: low_d = low_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    low_q <= low_d;
  end

  assign word          = {rx_byte, low_q};
  assign byte_idx      = idx_q;
  assign word_complete = accept & ~clear & (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Framed UART byte stream to instruction memory writer.
// Holds the CPU in reset during a load and checks a trailing checksum.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH  = 128,
  parameter int         ADDR_W = addr_w(DEPTH),
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [31:0]       WD,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e state_q, state_d;
  logic              rx_ready_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        widx_q, widx_d;

  logic        fire;
  logic        asm_acc;
  logic        asm_clr;
  logic [31:0] asm_word;
  logic [1:0]  asm_idx;
  logic        asm_done;

  assign fire    = RxValid & rx_ready_q;
  assign asm_acc = fire & (state_q == DATA);
  assign asm_clr = Reset | (fire & (state_q == LEN));

  word_assembler u_asm (
    .clk           (CLK),
    .rx_byte       (RxData),
    .accept        (asm_acc),
    .clear         (asm_clr),
    .word          (asm_word),
    .byte_idx      (asm_idx),
    .word_complete (asm_done)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    csum_d  = csum_q;
    n_d     = n_q;
    widx_d  = widx_q;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          if (RxData == SYNC) begin
            state_d = LEN;
            hold_d  = 1'b1;
            err_d   = 1'b0;
            csum_d  = 8'd0;
          end
        end
        LEN: begin
          if (RxData == 8'd0 || RxData > DEPTH_B) begin
            state_d = IDLE;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = DATA;
            n_d     = RxData;
            csum_d  = RxData;
            widx_d  = 8'd0;
          end
        end
        DATA: begin
          csum_d = csum_q + RxData;
          if (asm_done) begin
            we_d   = 1'b1;
            wa_d   = widx_q[ADDR_W-1:0];
            wd_d   = asm_word;
            widx_d = widx_q + 8'd1;
          end
          // Last byte of the last word hands over to the checksum byte.
          if (asm_idx == 2'd3 && widx_q == n_q - 8'd1)
            state_d = CSUM;
        end
        CSUM: begin
          state_d = IDLE;
          hold_d  = 1'b0;
          if (RxData == csum_q) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= 32'd0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csum_q     <= 8'd0;
      n_q        <= 8'd0;
      widx_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= 1'b1;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
      n_q        <= n_d;
      widx_q     <= widx_d;
    end
  end

  assign RxReady = rx_ready_q;
  assign WE      = we_q;
  assign WA      = wa_q;
  assign WD      = wd_q;
  assign CpuHold = hold_q;
  assign Done    = done_q;
  assign Error   = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Frames are built from word lists; writes and flags are checked per scenario.
module tb_instr_mem_loader;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  RxData = 8'd0;
  logic        RxValid = 1'b0;
  logic        RxReady;
  logic        WE;
  logic [6:0]  WA;
  logic [31:0] WD;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  instr_mem_loader dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .RxData  (RxData),
    .RxValid (RxValid),
    .RxReady (RxReady),
    .WE      (WE),
    .WA      (WA),
    .WD      (WD),
    .CpuHold (CpuHold),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int got_wa[$];
  logic [31:0] got_wd[$];
  int done_cnt = 0;
  logic [31:0] exp_words[$];

  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      got_wa.push_back(int'(WA));
      got_wd.push_back(WD);
    end
    if (Done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_wa.delete();
    got_wd.delete();
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(posedge CLK);
    #1;
    w = 0;
    while (RxReady !== 1'b1 && w < 16) begin
      @(posedge CLK);
      #1;
      w++;
    end
    if (RxReady !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_ready_wait: RxReady=%b required 1", RxReady);
    end
    RxData  = b;
    RxValid = 1'b1;
    @(posedge CLK);
    #1;
    RxValid = 1'b0;
    RxData  = 8'($urandom);
  endtask

  // Frame from exp_words; checksum is the byte-wise sum of length and data.
  task automatic send_frame(input bit bad, input int max_gap);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'(exp_words.size());
    send_byte(8'hA5, $urandom_range(0, max_gap));
    send_byte(cs, $urandom_range(0, max_gap));
    foreach (exp_words[i]) begin
      w = exp_words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], $urandom_range(0, max_gap));
        cs = cs + w[8*k +: 8];
      end
    end
    send_byte(bad ? cs + 8'd1 : cs, $urandom_range(0, max_gap));
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(3);
    n_chk++;
    if ({RxReady, WE, WA, WD, CpuHold, Done, Error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b wa=%0d wd=%h hold=%b done=%b err=%b required all 0",
               RxReady, WE, WA, WD, CpuHold, Done, Error);
    end
    Reset = 1'b0;
    tick(1);
    n_chk++;
    if (RxReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: RxReady=%b required 1", RxReady);
    end
    n_chk++;
    if ({WE, CpuHold, Done, Error} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: we=%b hold=%b done=%b err=%b required 0",
               WE, CpuHold, Done, Error);
    end
  endtask

  task automatic test_single();
    logic [7:0] bytes_q[$];
    clear_obs();
    bytes_q = {8'h01, 8'h04, 8'h12, 8'h9F, 8'hE5};
    n_chk++;
    if (CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold_pre: CpuHold=%b required 0", CpuHold);
    end
    send_byte(8'hA5, 1);
    n_chk++;
    if (CpuHold !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold_set: CpuHold=%b required 1", CpuHold);
    end
    foreach (bytes_q[i]) send_byte(bytes_q[i], 0);
    n_chk++;
    if (CpuHold !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold_mid: hold=%b done=%b required 1/0", CpuHold, Done);
    end
    send_byte(8'h9B, 2);
    n_chk++;
    if (Done !== 1'b1 || CpuHold !== 1'b0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: done=%b hold=%b err=%b required 1/0/0", Done, CpuHold, Error);
    end
    tick(3);
    n_chk++;
    if (got_wd.size() != 1 || got_wa[0] != 0 || got_wd[0] !== 32'hE59F1204) begin
      n_fail++;
      $display("FAIL single_write: n=%0d wa=%0d wd=%h required 1/0/e59f1204",
               got_wd.size(), got_wa.size() ? got_wa[0] : -1,
               got_wd.size() ? got_wd[0] : 32'hx);
    end
    n_chk++;
    if (done_cnt != 1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: count=%0d now=%b required 1/0", done_cnt, Done);
    end
  endtask

  task automatic test_multi();
    clear_obs();
    exp_words = {32'hE59F1204, 32'hE59F9204, 32'hE59F8204};
    send_frame(1'b0, 5);
    tick(3);
    n_chk++;
    if (got_wd.size() != 3) begin
      n_fail++;
      $display("FAIL multi_count: writes=%0d required 3", got_wd.size());
    end
    for (int i = 0; i < 3 && i < got_wd.size(); i++) begin
      n_chk++;
      if (got_wa[i] != i || got_wd[i] !== exp_words[i]) begin
        n_fail++;
        $display("FAIL multi_word%0d: wa=%0d wd=%h required %0d/%h",
                 i, got_wa[i], got_wd[i], i, exp_words[i]);
      end
    end
    n_chk++;
    if (done_cnt != 1 || Error !== 1'b0 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_flags: done=%0d err=%b hold=%b required 1/0/0",
               done_cnt, Error, CpuHold);
    end
  endtask

  task automatic test_bad_csum();
    clear_obs();
    exp_words = {32'hE59F1204};
    send_frame(1'b1, 2);
    tick(3);
    n_chk++;
    if (got_wd.size() != 1 || got_wa[0] != 0 || got_wd[0] !== 32'hE59F1204) begin
      n_fail++;
      $display("FAIL badcs_write: writes=%0d required 1 at 0 with e59f1204", got_wd.size());
    end
    n_chk++;
    if (Error !== 1'b1 || done_cnt != 0 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL badcs_flags: err=%b done=%0d hold=%b required 1/0/0",
               Error, done_cnt, CpuHold);
    end
    send_byte(8'h3C, 4);
    tick(2);
    n_chk++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL badcs_sticky: err=%b required 1", Error);
    end
  endtask

  task automatic test_bad_len();
    clear_obs();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    n_chk++;
    if (Error !== 1'b1 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL badlen_zero: err=%b hold=%b required 1/0", Error, CpuHold);
    end
    send_byte(8'hA5, 2);
    n_chk++;
    if (Error !== 1'b0 || CpuHold !== 1'b1) begin
      n_fail++;
      $display("FAIL badlen_sync_clear: err=%b hold=%b required 0/1", Error, CpuHold);
    end
    send_byte(8'h81, 0);
    n_chk++;
    if (Error !== 1'b1 || CpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL badlen_129: err=%b hold=%b required 1/0", Error, CpuHold);
    end
    // In IDLE the next bytes are noise; nothing may be written.
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    tick(2);
    n_chk++;
    if (got_wd.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL badlen_nowrite: writes=%0d done=%0d required 0/0", got_wd.size(), done_cnt);
    end
    exp_words = {$urandom, $urandom};
    send_frame(1'b0, 2);
    tick(3);
    n_chk++;
    if (got_wd.size() != 2 || got_wd[0] !== exp_words[0] || got_wd[1] !== exp_words[1]
        || got_wa[1] != 1) begin
      n_fail++;
      $display("FAIL badlen_recover_write: writes=%0d required 2 matching", got_wd.size());
    end
    n_chk++;
    if (Error !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL badlen_recover_flags: err=%b done=%0d required 0/1", Error, done_cnt);
    end
  endtask

  task automatic test_noise_reset();
    clear_obs();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 0);
    n_chk++;
    if (CpuHold !== 1'b0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL noise_ignored: hold=%b err=%b required 0/0", CpuHold, Error);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    Reset = 1'b1;
    tick(1);
    n_chk++;
    if ({RxReady, WE, WA, WD, CpuHold, Done, Error} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rdy=%b we=%b wa=%0d wd=%h hold=%b done=%b err=%b required all 0",
               RxReady, WE, WA, WD, CpuHold, Done, Error);
    end
    Reset = 1'b0;
    tick(2);
    n_chk++;
    if (got_wd.size() != 0 || RxReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_nowrite: writes=%0d rdy=%b required 0/1", got_wd.size(), RxReady);
    end
    exp_words = {$urandom, $urandom};
    send_frame(1'b0, 3);
    tick(3);
    n_chk++;
    if (got_wd.size() != 2 || got_wa[0] != 0 || got_wd[0] !== exp_words[0]
        || got_wa[1] != 1 || got_wd[1] !== exp_words[1]) begin
      n_fail++;
      $display("FAIL midreset_fresh: writes=%0d required 2 at WA 0,1", got_wd.size());
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL midreset_done: done=%0d required 1", done_cnt);
    end
  endtask

  task automatic test_full_depth();
    int bad_idx;
    clear_obs();
    exp_words.delete();
    for (int i = 0; i < 128; i++) exp_words.push_back(32'(i));
    send_frame(1'b0, 0);
    tick(3);
    bad_idx = -1;
    for (int i = 0; i < 128 && i < got_wd.size(); i++)
      if (bad_idx < 0 && (got_wa[i] != i || got_wd[i] !== exp_words[i])) bad_idx = i;
    n_chk++;
    if (got_wd.size() != 128 || bad_idx >= 0) begin
      n_fail++;
      $display("FAIL full_writes: writes=%0d first_bad=%0d required 128/-1",
               got_wd.size(), bad_idx);
    end
    n_chk++;
    if (got_wd.size() == 0 || got_wa[$] != 127 || got_wd[$] !== 32'h0000007F) begin
      n_fail++;
      $display("FAIL full_last: wa=%0d wd=%h required 127/0000007f",
               got_wa.size() ? got_wa[$] : -1, got_wd.size() ? got_wd[$] : 32'hx);
    end
    n_chk++;
    if (done_cnt != 1 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%0d err=%b required 1/0", done_cnt, Error);
    end
  endtask

  task automatic test_random_frames();
    int n;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      clear_obs();
      exp_words.delete();
      n = $urandom_range(1, 6);
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      send_frame(bad, 4);
      tick(3);
      for (int i = 0; i < n; i++) begin
        n_chk++;
        if (i >= got_wd.size() || got_wa[i] != i || got_wd[i] !== exp_words[i]) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: writes=%0d required %h at %0d",
                   it, i, got_wd.size(), exp_words[i], i);
        end
      end
      n_chk++;
      if (got_wd.size() != n || done_cnt != (bad ? 0 : 1) || Error !== bad) begin
        n_fail++;
        $display("FAIL rand%0d_flags: writes=%0d done=%0d err=%b required %0d/%0d/%b",
                 it, got_wd.size(), done_cnt, Error, n, bad ? 0 : 1, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_bad_csum();
    test_bad_len();
    test_noise_reset();
    test_full_depth();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
